// File: rtl/arm_seq_alu_if.sv
// Request/response bundle between the decoder/controller and the multi-cycle ALU.
// The master issues operations; the slave (the ALU) returns results and status.
interface arm_seq_alu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic [3:0]       flags;
  logic             illegal;

  modport master (
    output start, op, a, b,
    input  ready, done, result, result_hi, flags, illegal
  );

  modport slave (
    input  start, op, a, b,
    output ready, done, result, result_hi, flags, illegal
  );
endinterface

// File: rtl/arm_seq_alu.sv
// Multi-cycle ALU: single-cycle ADD/SUB/AND/ORR/EOR plus iterative shift-add
// MUL/UMULL retiring STEP multiplier bits per cycle.
module arm_seq_alu #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input logic           clk,
  input logic           reset,
  arm_seq_alu_if.slave  bus
);
  localparam int N  = WIDTH / STEP;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_AND   = 3'b010,
    OP_ORR   = 3'b011,
    OP_EOR   = 3'b100,
    OP_MUL   = 3'b101,
    OP_UMULL = 3'b110,
    OP_ILL   = 3'b111
  } op_t;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state;
  op_t                op;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;
  logic               is_umull;
  logic               done_q;
  logic               illegal_q;
  logic [WIDTH-1:0]   result_q;
  logic [WIDTH-1:0]   result_hi_q;
  logic [3:0]         flags_q;

  logic [WIDTH-1:0]   b_eff;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   sc_res;
  logic               sc_c;
  logic               sc_v;
  logic [3:0]         sc_flags;
  logic [2*WIDTH-1:0] acc_next;

  assign op = op_t'(bus.op);

  // NOTE: every always_comb output gets a default before the case so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    b_eff  = bus.op[0] ? ~bus.b : bus.b;
    sum    = {1'b0, bus.a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, bus.op[0]};
    sc_res = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        sc_res = sum[WIDTH-1:0];
        sc_c   = sum[WIDTH];
        sc_v   = (bus.a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_AND:  sc_res = bus.a & bus.b;
      OP_ORR:  sc_res = bus.a | bus.b;
      OP_EOR:  sc_res = bus.a ^ bus.b;
      default: sc_res = '0;  // op 111 then yields flags 0100 naturally
    endcase
    sc_flags = {sc_res[WIDTH-1], (sc_res == '0), sc_c, sc_v};
    acc_next = acc + (mcand * {{(2*WIDTH-STEP){1'b0}}, mplier[STEP-1:0]});
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      mcand       <= '0;
      mplier      <= '0;
      acc         <= '0;
      cnt         <= '0;
      is_umull    <= 1'b0;
      done_q      <= 1'b0;
      illegal_q   <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      flags_q     <= '0;
    end else begin
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (op == OP_MUL || op == OP_UMULL) begin
              mcand    <= {{WIDTH{1'b0}}, bus.a};
              mplier   <= bus.b;
              acc      <= '0;
              cnt      <= CW'(N);
              is_umull <= (op == OP_UMULL);
              state    <= BUSY;
            end else begin
              result_q    <= sc_res;
              result_hi_q <= '0;
              flags_q     <= sc_flags;
              illegal_q   <= (op == OP_ILL);
              done_q      <= 1'b1;
            end
          end
        end
        BUSY: begin
          acc    <= acc_next;
          mcand  <= mcand << STEP;
          mplier <= mplier >> STEP;
          cnt    <= cnt - CW'(1);
          // Last iteration: publish straight from the adder output.
          if (cnt == CW'(1)) begin
            result_q    <= acc_next[WIDTH-1:0];
            result_hi_q <= is_umull ? acc_next[2*WIDTH-1:WIDTH] : '0;
            flags_q     <= is_umull
                         ? {acc_next[2*WIDTH-1], (acc_next == '0), 2'b00}
                         : {acc_next[WIDTH-1], (acc_next[WIDTH-1:0] == '0), 2'b00};
            done_q      <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready     = (state == IDLE);
  assign bus.done      = done_q;
  assign bus.illegal   = illegal_q;
  assign bus.result    = result_q;
  assign bus.result_hi = result_hi_q;
  assign bus.flags     = flags_q;
endmodule

// File: doc/arm_seq_alu.md
# arm_seq_alu

Parametrised multi-cycle execution unit for the ARM core family. It extends the single-cycle ADD/SUB/AND/ORR ALU with a configurable datapath width and an EOR operation. It also adds iterative MUL/UMULL, with operands captured under a start/ready/done handshake. It sits between the decoder and the result mux of the multicycle core, and the controller stalls on `ready`.

## Interface
- `WIDTH`, default 32: operand/result width; must be ≥ 4.
- `STEP`, default 1: multiplier bits retired per iteration; must divide `WIDTH`. `N = WIDTH/STEP`.
- `clk`  in  1: clock.
- `reset`  in  1: reset, asynchronous, active-high.
- `start`  in  1: request; sampled only when `ready`=1.
- `op`  in  3: 000 ADD, 001 SUB (a−b), 010 AND, 011 ORR, 100 EOR, 101 MUL (low half), 110 UMULL (full product), 111 reserved.
- `a`, `b`  in  WIDTH: operands; captured on the accept edge.
- `ready`  out  1: unit idle, can accept.
- `done`  out  1: one-cycle pulse; result/flags valid.
- `result`  out  WIDTH: result, or low half of the product.
- `result_hi`  out  WIDTH: high half of the product for UMULL; 0 for all other ops.
- `flags`  out  4: {N,Z,C,V}.
- `illegal`  out  1: pulses with `done` for op 111.

## Operation
- States: IDLE, MUL. `ready` = (state==IDLE).
- Accept = `start` & `ready` at a rising edge.
- Reset: state IDLE; `ready`=1; `done`=0; `illegal`=0; `result`=0; `result_hi`=0; `flags`=0000; iteration counter 0.
- Single-cycle ops (000–100, 111):
  - On the accept edge, the computed value is registered into `result`/`flags`.
  - `done`=1 for the following cycle; state stays IDLE.
- ADD/SUB use a (WIDTH+1)-bit sum: `a + (b or ~b) + op[0]`.
  - C = carry out; for SUB, C=1 means no borrow.
  - V = signed overflow: operand MSBs agree (b inverted for SUB) and the sum MSB differs.
- AND/ORR/EOR: C=0, V=0.
- All single-cycle ops: N = `result[WIDTH-1]`; Z = (`result`==0).
- Op 111: `result`=0, `result_hi`=0, `flags`=0100, `illegal`=1 with `done`.
- MUL/UMULL accept:
  - Latch the multiplicand (zero-extended to 2·WIDTH) and the multiplier.
  - Clear the 2·WIDTH accumulator; counter ← N; state → MUL.
- Each MUL-state edge performs one shift-add iteration:
  - acc += multiplicand × multiplier[STEP-1:0].
  - multiplicand <<= STEP; multiplier >>= STEP; counter −1.
- On the edge where the counter reaches 0:
  - Register `result` = acc[WIDTH-1:0].
  - Register `result_hi` = acc[2W-1:W] for UMULL, else 0.
  - Flags: MUL gives N = `result` MSB, Z = (`result`==0), C=0, V=0. UMULL gives N = `result_hi` MSB, Z = (full product==0), C=0, V=0.
  - `done`=1 next cycle; state → IDLE.
- `start` while `ready`=0 is ignored; it is not queued and the operands are not sampled.
- `result`, `result_hi`, `flags` hold their last values until the next completion; they are not cleared at accept.
- Back-to-back: `start` may be accepted in the same cycle that `done` is high.
- Reset mid-MUL aborts the operation: no `done`, and the outputs return to their reset values.

## Timing
- Accept edge E, single-cycle op: `done` is high in the cycle after E; sustained throughput is 1 op/cycle.
- Accept edge E, MUL/UMULL:
  - `ready`=0 for exactly N cycles (after E through edge E+N).
  - `done` and `ready` both go high in the cycle after edge E+N.
  - Total latency is N cycles longer than a single-cycle op.
- All outputs are registered; there is no combinational path from inputs to outputs except none at all. `ready` is a decode of the state register only.

## Test plan
1. **Reset:** assert `reset` async mid-cycle. Required: `ready`=1, `done`=0, `result`=0, `result_hi`=0, `flags`=0000 immediately.
2. **ADD overflow** (WIDTH=32): ADD 0x7FFFFFFF + 0x00000001. Required: `result`=0x80000000, `flags`=1001, `done` 1 cycle after accept.
3. **SUB / logic:**
   - SUB 5 − 5 → `result`=0, `flags`=0110.
   - SUB 3 − 5 → 0xFFFFFFFE, `flags`=1000.
   - EOR 0xF0F0F0F0 ^ 0xFFFFFFFF → 0x0F0F0F0F, `flags`=0000.
   - Issue all back-to-back, one per cycle; all three `done` pulses are required.
4. **Multiply** (STEP=1):
   - MUL 0xFFFFFFFF × 0xFFFFFFFF → `result`=0x00000001, `result_hi`=0, `flags`=0000, with `ready` low exactly 32 cycles.
   - UMULL with the same operands → `result_hi`=0xFFFFFFFE, `result`=0x00000001, `flags`=1000.
5. **Busy / abort:**
   - A `start` (ADD 1+1) during MUL is ignored: only one `done`, and it carries the MUL result.
   - A `reset` at cycle 10 of a MUL gives no `done` and `ready`=1.
6. **Parametrisation:**
   - WIDTH=16, STEP=4: MUL 7 × 6 → `result`=0x002A with `ready` low 4 cycles.
   - UMULL 0xFFFF × 0x0002 → `result_hi`=0x0001, `result`=0xFFFE.
   - Op 111 → `illegal` and `done` pulse together, `flags`=0100.
